// File: rtl/pll_cen_gen_if.sv
// pll_cen_gen_if: runtime increment-update channel for pll_cen_gen.
// Valid/ready handshake; a transfer happens when cfg_valid and cfg_ready are both high.
interface pll_cen_gen_if #(
  parameter int CHAN_W = 2,
  parameter int ACC_W  = 32
);
  logic              cfg_valid;
  logic              cfg_ready;
  logic [CHAN_W-1:0] cfg_chan;
  logic [ACC_W-1:0]  cfg_inc;

  modport master (
    output cfg_valid,
    output cfg_chan,
    output cfg_inc,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_chan,
    input  cfg_inc,
    output cfg_ready
  );
endinterface

// File: rtl/pll_cen_gen.sv
// pll_cen_gen: phase-accumulator clock enables, released once PLL lock has been stable.
// Define PLL_CEN_ALIGN_EN to add align_i, which restarts all channel phases together.
module pll_cen_gen #(
  parameter int                        CHANNELS    = 3,
  parameter int                        ACC_W       = 32,
  parameter int                        LOCK_CYCLES = 1024,
  parameter logic [CHANNELS*ACC_W-1:0] INC_INIT    = '0
) (
  input  logic                refclk,
  input  logic                rst_n,
  input  logic                locked_i,
`ifdef PLL_CEN_ALIGN_EN
  input  logic                align_i,
`endif
  pll_cen_gen_if.slave        cfg,
  output logic                ready_o,
  output logic [CHANNELS-1:0] cen_o
);

  localparam int CHAN_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int CNT_W  = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  localparam logic [1:0] WAIT_LOCK = 2'd0;
  localparam logic [1:0] STABLE    = 2'd1;
  localparam logic [1:0] RUN       = 2'd2;

  logic                lk_meta_q;
  logic                lk_s_q;
  logic [1:0]          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ready_q, ready_d;
  logic [CHANNELS-1:0] cen_q, cen_d;
  logic [ACC_W-1:0]    acc_q [CHANNELS];
  logic [ACC_W-1:0]    acc_d [CHANNELS];
  logic [ACC_W-1:0]    inc_q [CHANNELS];
  logic [ACC_W-1:0]    inc_d [CHANNELS];
  logic                pend_q, pend_d;
  logic [CHAN_W-1:0]   pend_chan_q, pend_chan_d;
  logic [ACC_W-1:0]    pend_inc_q, pend_inc_d;

  logic                run_act;
  logic                align_hit;
  logic                apply;
  logic                tgt_valid;
  logic                tgt_carry;
  logic                tgt_zero;
  logic [CHANNELS-1:0] carry;
  logic [ACC_W:0]      sum [CHANNELS];

  // Lock-stability FSM
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      WAIT_LOCK: begin
        cnt_d = '0;
        if (lk_s_q) state_d = STABLE;
      end
      STABLE: begin
        cnt_d = cnt_q + 1'b1;
        if (!lk_s_q) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(LOCK_CYCLES - 1)) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (!lk_s_q) state_d = WAIT_LOCK;
      end
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase
    ready_d = (state_d == RUN);
  end

  // Accumulators advance only while RUN is held; the lock-loss cycle already clears them.
  assign run_act = (state_q == RUN) && lk_s_q;

`ifdef PLL_CEN_ALIGN_EN
  assign align_hit = align_i && run_act;
`else
  assign align_hit = 1'b0;
`endif

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      sum[i]   = {1'b0, acc_q[i]} + {1'b0, inc_q[i]};
      carry[i] = sum[i][ACC_W];
    end
  end

  always_comb begin
    tgt_valid = 1'b0;
    tgt_carry = 1'b0;
    tgt_zero  = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (pend_chan_q == CHAN_W'(i)) begin
        tgt_valid = 1'b1;
        tgt_carry = carry[i];
        tgt_zero  = (inc_q[i] == '0);
      end
    end
  end

  // Swapping the increment on the target's own carry keeps its pulse spacing glitch-free;
  // an out-of-range channel is simply dropped on the cycle after acceptance.
  assign apply = pend_q && (!tgt_valid || !run_act || tgt_zero || tgt_carry);

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      acc_d[i] = (run_act && !align_hit) ? sum[i][ACC_W-1:0] : '0;
      inc_d[i] = inc_q[i];
      if (apply && tgt_valid && (pend_chan_q == CHAN_W'(i))) inc_d[i] = pend_inc_q;
    end
    cen_d = (run_act && !align_hit) ? carry : '0;
  end

  always_comb begin
    pend_d      = pend_q;
    pend_chan_d = pend_chan_q;
    pend_inc_d  = pend_inc_q;
    if (!pend_q && cfg.cfg_valid) begin
      pend_d      = 1'b1;
      pend_chan_d = cfg.cfg_chan;
      pend_inc_d  = cfg.cfg_inc;
    end else if (apply) begin
      pend_d = 1'b0;
    end
  end

  assign cfg.cfg_ready = !pend_q;
  assign ready_o       = ready_q;
  assign cen_o         = cen_q;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      lk_meta_q   <= 1'b0;
      lk_s_q      <= 1'b0;
      state_q     <= WAIT_LOCK;
      cnt_q       <= '0;
      ready_q     <= 1'b0;
      cen_q       <= '0;
      pend_q      <= 1'b0;
      pend_chan_q <= '0;
      pend_inc_q  <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        acc_q[i] <= '0;
        inc_q[i] <= INC_INIT[i*ACC_W +: ACC_W];
      end
    end else begin
      lk_meta_q   <= locked_i;
      lk_s_q      <= lk_meta_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ready_q     <= ready_d;
      cen_q       <= cen_d;
      pend_q      <= pend_d;
      pend_chan_q <= pend_chan_d;
      pend_inc_q  <= pend_inc_d;
      for (int i = 0; i < CHANNELS; i++) begin
        acc_q[i] <= acc_d[i];
        inc_q[i] <= inc_d[i];
      end
    end
  end

endmodule

// File: tb/tb_pll_cen_gen.sv
// tb_pll_cen_gen: directed bench for pll_cen_gen (CHANNELS=3, ACC_W=8, LOCK_CYCLES=16).
// Define PLL_CEN_ALIGN_EN to also exercise the align input.
module tb_pll_cen_gen;

  logic       refclk = 1'b0;
  logic       rst_n  = 1'b0;
  logic       locked = 1'b0;
  logic       align  = 1'b0;
  logic       ready;
  logic [2:0] cen;

  int n_chk = 0;
  int n_bad = 0;
  int cnt [3];
  int first [3];
  int last [3];
  int gap_bad;

  pll_cen_gen_if #(.CHAN_W(2), .ACC_W(8)) cfg_if ();

  pll_cen_gen #(
    .CHANNELS    (3),
    .ACC_W       (8),
    .LOCK_CYCLES (16),
    .INC_INIT    ({8'd64, 8'd85, 8'd128})
  ) dut (
    .refclk   (refclk),
    .rst_n    (rst_n),
    .locked_i (locked),
`ifdef PLL_CEN_ALIGN_EN
    .align_i  (align),
`endif
    .cfg      (cfg_if.slave),
    .ready_o  (ready),
    .cen_o    (cen)
  );

  always #5 refclk = ~refclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic wait_rdy(input string tag);
    int n = 0;
    while (!cfg_if.cfg_ready && n < 600) begin
      tick();
      n++;
    end
    chk(tag, 32'(cfg_if.cfg_ready), 1);
  endtask

  task automatic send(input logic [1:0] ch, input logic [7:0] inc);
    cfg_if.cfg_chan  = ch;
    cfg_if.cfg_inc   = inc;
    cfg_if.cfg_valid = 1'b1;
    tick();
    cfg_if.cfg_valid = 1'b0;
  endtask

  task automatic count_win();
    for (int c = 0; c < 3; c++) begin
      cnt[c] = 0; first[c] = 0; last[c] = 0;
    end
    gap_bad = 0;
    for (int k = 1; k <= 256; k++) begin
      tick();
      for (int c = 0; c < 3; c++) begin
        if (cen[c]) begin
          cnt[c]++;
          if (first[c] == 0) first[c] = k;
          if (last[c] != 0 && c == 0 && k - last[c] != 2) gap_bad++;
          if (last[c] != 0 && c == 2 && k - last[c] != 4) gap_bad++;
          last[c] = k;
        end
      end
    end
  endtask

  initial begin
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_chan  = '0;
    cfg_if.cfg_inc   = '0;

    repeat (3) tick();
    chk("rst_cen", 32'(cen), 0);
    chk("rst_ready", 32'(ready), 0);
    chk("rst_cfg_ready", 32'(cfg_if.cfg_ready), 1);
    rst_n = 1'b1;
    tick();

    locked = 1'b1;
    repeat (18) tick();
    chk("lock_e18", 32'(ready), 0);
    tick();
    chk("lock_e19", 32'(ready), 1);

    // Restart from reset, glitching lock low at edge 10
    rst_n  = 1'b0;
    locked = 1'b0;
    #1;
    chk("arst_ready", 32'(ready), 0);
    chk("arst_cen", 32'(cen), 0);
    tick();
    rst_n = 1'b1;
    tick();
    locked = 1'b1;
    repeat (9) tick();
    locked = 1'b0;
    tick();
    locked = 1'b1;
    repeat (9) tick();
    chk("glitch_e19", 32'(ready), 0);
    repeat (9) tick();
    chk("glitch_e28", 32'(ready), 0);
    tick();
    chk("glitch_e29", 32'(ready), 1);

    count_win();
    chk("rate_cnt0", 32'(cnt[0]), 128);
    chk("rate_cnt1", 32'(cnt[1]), 85);
    chk("rate_cnt2", 32'(cnt[2]), 64);
    chk("rate_first0", 32'(first[0]), 2);
    chk("rate_first1", 32'(first[1]), 4);
    chk("rate_first2", 32'(first[2]), 4);
    chk("rate_gaps", 32'(gap_bad), 0);

    locked = 1'b0;
    tick();
    tick();
    chk("loss_e2_ready", 32'(ready), 1);
    tick();
    chk("loss_e3_ready", 32'(ready), 0);
    chk("loss_e3_cen", 32'(cen), 0);
    repeat (5) tick();
    chk("loss_hold_cen", 32'(cen), 0);
    locked = 1'b1;
    repeat (18) tick();
    chk("relock_e18", 32'(ready), 0);
    tick();
    chk("relock_e19", 32'(ready), 1);
    for (int k = 1; k <= 4; k++) begin
      logic [2:0] exp_cen;
      tick();
      exp_cen = (k == 2) ? 3'b001 : (k == 4) ? 3'b111 : 3'b000;
      chk($sformatf("relock_cen_k%0d", k), 32'(cen), 32'(exp_cen));
    end

    // ch2 64 -> 32, applied on its next carry at k=8
    cfg_if.cfg_chan  = 2'd2;
    cfg_if.cfg_inc   = 8'd32;
    cfg_if.cfg_valid = 1'b1;
    for (int k = 5; k <= 24; k++) begin
      tick();
      if (k == 5) cfg_if.cfg_valid = 1'b0;
      chk($sformatf("recfg_rdy_k%0d", k), 32'(cfg_if.cfg_ready), 32'(k >= 8));
      chk($sformatf("recfg_cen2_k%0d", k), 32'(cen[2]), 32'(k == 8 || k == 16 || k == 24));
    end

    // Invalid channel, then a second request taken as cfg_ready returns
    cfg_if.cfg_chan  = 2'd3;
    cfg_if.cfg_inc   = 8'd7;
    cfg_if.cfg_valid = 1'b1;
    tick();
    chk("inv_accept", 32'(cfg_if.cfg_ready), 0);
    cfg_if.cfg_chan = 2'd1;
    cfg_if.cfg_inc  = 8'd255;
    tick();
    chk("inv_return", 32'(cfg_if.cfg_ready), 1);
    tick();
    chk("second_accept", 32'(cfg_if.cfg_ready), 0);
    cfg_if.cfg_valid = 1'b0;
    wait_rdy("max_apply_wait");
    count_win();
    chk("max_cnt0", 32'(cnt[0]), 128);
    chk("max_cnt1", 32'(cnt[1]), 255);
    chk("max_cnt2", 32'(cnt[2]), 32);

    send(2'd1, 8'd0);
    wait_rdy("zero_apply_wait");
    count_win();
    chk("zero_cnt1", 32'(cnt[1]), 0);

    send(2'd1, 8'd85);
    chk("zero_imm_accept", 32'(cfg_if.cfg_ready), 0);
    tick();
    chk("zero_imm_ready", 32'(cfg_if.cfg_ready), 1);
    count_win();
    chk("restore_cnt1", 32'(cnt[1]), 85);

`ifdef PLL_CEN_ALIGN_EN
    send(2'd2, 8'd64);
    wait_rdy("align_prep_wait");
    repeat (3) tick();
    align = 1'b1;
    tick();
    align = 1'b0;
    chk("align_clr", 32'(cen), 0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk($sformatf("align_cen0_k%0d", k), 32'(cen[0]), 32'(k % 2 == 0));
      chk($sformatf("align_cen2_k%0d", k), 32'(cen[2]), 32'(k % 4 == 0));
    end
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
